// File: rtl/fp16_maxpool_stream.sv
// Streaming FP16 max-pool over windows of POOL_SIZE beats (early close on in_last); FP16_NAN_STICKY_EN forces qNaN for NaN-bearing windows.
// Latency: window maximum appears on out_valid one cycle after the closing beat is accepted.
// Backpressure: in_ready = ~out_valid | out_ready; a held result stalls input, a pop and a close may share one edge.
module fp16_maxpool_stream #(
  parameter int POOL_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [8:0]  out_len
);

  localparam int               CNT_W    = $clog2(POOL_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0] cnt;
  logic [15:0]      run_max;
  logic             accept;
  logic             closing;
  logic             beat_wins;
  logic [15:0]      win_max;
  logic [15:0]      close_dat;

  // Monotone remap of binary16 so an unsigned compare gives -inf < ... < -0 < +0 < ... < +inf.
  function automatic logic [15:0] order_key(input logic [15:0] v);
    return v[15] ? ~v : (v | 16'h8000);
  endfunction

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign closing   = accept & (in_last | (cnt == CNT_LAST));
  // Strict compare: an equal key keeps the earlier element.
  assign beat_wins = (cnt == '0) | (order_key(in_data) > order_key(run_max));
  assign win_max   = beat_wins ? in_data : run_max;

`ifdef FP16_NAN_STICKY_EN
  logic nan_seen;
  logic in_nan;

  assign in_nan    = (in_data[14:10] == 5'h1F) & (|in_data[9:0]);
  assign close_dat = (nan_seen | in_nan) ? 16'h7E00 : win_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_seen <= 1'b0;
    end else if (closing) begin
      nan_seen <= 1'b0;
    end else if (accept && in_nan) begin
      nan_seen <= 1'b1;
    end
  end
`else
  assign close_dat = win_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_max <= 16'h0000;
    end else if (closing) begin
      cnt     <= '0;
      run_max <= 16'h0000;
    end else if (accept) begin
      cnt     <= cnt + CNT_W'(1);
      run_max <= win_max;
    end
  end

  // A close reloads the output even when the same edge pops the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_len   <= 9'd0;
    end else if (closing) begin
      out_valid <= 1'b1;
      out_data  <= close_dat;
      out_len   <= 9'(cnt) + 9'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
